// File: rtl/svr_multi_protocol_monitor.sv
// svr_multi_protocol_monitor
//   Passive monitor for NUM_CH independent valid/ready channels. It only
//   observes the bus. For each channel it tracks the pending transfer,
//   checks that data stays stable and valid stays high while stalled, and
//   flags stall timeouts. It also keeps a transfer count and the longest
//   stall seen. The sticky flags and counters feed a debug/status CSR block.
// Ports
//   clk                posedge clock
//   rst                synchronous reset, active low
//   clr                synchronous clear of counters, max_stall and sticky flags
//   mon_valid/ready    per-channel handshake, channel i at bit i
//   mon_data           channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_*              sticky per-channel violation flags
//   err_irq            OR of all sticky flags
//   xfer_cnt           accepted transfers per channel, [i*CNT_WIDTH +: CNT_WIDTH]
//   max_stall          longest finished stall per channel, [i*STALL_W +: STALL_W]

// Per-channel tracker: a two-state FSM plus the statistics for one channel.
module svr_mon_ch #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int STALL_W    = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  valid,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  err_data_unstable,
  output logic                  err_valid_drop,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [STALL_W-1:0]    max_stall
);
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_W-1:0] TO_VAL    = STALL_W'(TIMEOUT);

  state_t                state, state_nxt;
  logic [STALL_W-1:0]    stall, stall_nxt;
  logic [DATA_WIDTH-1:0] cap, cap_nxt;
  logic                  ev_xfer, ev_unstable, ev_drop, ev_exit, ev_timeout;

  always_comb begin
    state_nxt   = state;
    stall_nxt   = stall;
    cap_nxt     = cap;
    ev_xfer     = 1'b0;
    ev_unstable = 1'b0;
    ev_drop     = 1'b0;
    ev_exit     = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (ready) begin
            ev_xfer = 1'b1;
          end else begin
            state_nxt = PEND;
            cap_nxt   = data;
            stall_nxt = STALL_W'(1);
          end
        end
      end
      PEND: begin
        if (!valid) begin
          // Valid withdrawn: no data check on this cycle.
          ev_drop   = 1'b1;
          ev_exit   = 1'b1;
          state_nxt = IDLE;
          stall_nxt = '0;
        end else begin
          // Captured data is deliberately not refreshed, so every later
          // differing beat keeps comparing against the original value.
          ev_unstable = (data != cap);
          if (ready) begin
            ev_xfer   = 1'b1;
            ev_exit   = 1'b1;
            state_nxt = IDLE;
            stall_nxt = '0;
          end else if (stall != STALL_MAX) begin
            stall_nxt = stall + STALL_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        stall_nxt = '0;
      end
    endcase
  end

  // Fires only on the crossing edge, so a clr mid-stall does not re-arm it
  // until the next stall reaches the threshold again.
  assign ev_timeout = (TIMEOUT != 0) && (state_nxt == PEND) &&
                      (stall < TO_VAL) && (stall_nxt >= TO_VAL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      stall             <= '0;
      cap               <= '0;
      xfer_cnt          <= '0;
      max_stall         <= '0;
      err_data_unstable <= 1'b0;
      err_valid_drop    <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      // Tracking continues through clr so a stall spanning it is measured in full.
      state <= state_nxt;
      stall <= stall_nxt;
      cap   <= cap_nxt;
      if (clr) begin
        xfer_cnt          <= '0;
        max_stall         <= '0;
        err_data_unstable <= 1'b0;
        err_valid_drop    <= 1'b0;
        err_timeout       <= 1'b0;
      end else begin
        if (ev_xfer)                     xfer_cnt          <= xfer_cnt + CNT_WIDTH'(1);
        if (ev_exit && stall > max_stall) max_stall        <= stall;
        if (ev_unstable)                 err_data_unstable <= 1'b1;
        if (ev_drop)                     err_valid_drop    <= 1'b1;
        if (ev_timeout)                  err_timeout       <= 1'b1;
      end
    end
  end
endmodule

module svr_multi_protocol_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int STALL_W    = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [NUM_CH-1:0]            mon_valid,
  input  logic [NUM_CH-1:0]            mon_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] mon_data,
  output logic [NUM_CH-1:0]            err_data_unstable,
  output logic [NUM_CH-1:0]            err_valid_drop,
  output logic [NUM_CH-1:0]            err_timeout,
  output logic                         err_irq,
  output logic [NUM_CH*CNT_WIDTH-1:0]  xfer_cnt,
  output logic [NUM_CH*STALL_W-1:0]    max_stall
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    svr_mon_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .STALL_W    (STALL_W),
      .TIMEOUT    (TIMEOUT)
    ) u_ch (
      .clk               (clk),
      .rst               (rst),
      .clr               (clr),
      .valid             (mon_valid[g]),
      .ready             (mon_ready[g]),
      .data              (mon_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .err_data_unstable (err_data_unstable[g]),
      .err_valid_drop    (err_valid_drop[g]),
      .err_timeout       (err_timeout[g]),
      .xfer_cnt          (xfer_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
      .max_stall         (max_stall[g*STALL_W +: STALL_W])
    );
  end

  assign err_irq = |{err_data_unstable, err_valid_drop, err_timeout};
endmodule
